speaker_control: RTL and testbench

//   Downstream of the tone/volume stage. Serialises the 16-bit stereo samples
//   (audio_left/audio_right) into the I2S stream for the on-board DAC: MCLK, LRCK, SCK, SDIN.
//   All outputs are derived from one free-running divider counter in the system clock domain.

---
 rtl/speaker_control_pkg.sv | 31 +++
 rtl/speaker_control_clk_gen.sv | 47 ++++
 rtl/speaker_control.sv | 77 +++++++
 tb/tb_speaker_control.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speaker_control_pkg.sv
// Shared constants for the speaker/I2S output path and the buzzer note table.
// Optional feature macro: SPEAKER_MUTE_EN (see speaker_control.sv).
package speaker_control_pkg;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned LRCK_BIT_DEF = 9;
  localparam int unsigned MCLK_BIT_DEF = 1;

  // Note divider half-periods in 100 MHz clk cycles (C4, D4, E4).
  localparam int unsigned NOTE_DO_HALF = 191110;
  localparam int unsigned NOTE_RE_HALF = 170265;
  localparam int unsigned NOTE_MI_HALF = 151685;

  typedef enum logic [1:0] {
    NOTE_DO,
    NOTE_RE,
    NOTE_MI
  } note_e;

  function automatic int unsigned note_half_period(input note_e n);
    int unsigned hp;
    case (n)
      NOTE_DO: hp = NOTE_DO_HALF;
      NOTE_RE: hp = NOTE_RE_HALF;
      NOTE_MI: hp = NOTE_MI_HALF;
      default: hp = NOTE_DO_HALF;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/speaker_control_clk_gen.sv
// I2S timing generator: one free-running divider counter; MCLK/SCK/LRCK are
// direct counter bits, plus the slot-boundary and sample-capture strobes.
module i2s_clk_gen
  import speaker_control_pkg::*;
#(
  parameter int unsigned LRCK_BIT = LRCK_BIT_DEF,
  parameter int unsigned MCLK_BIT = MCLK_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic mclk_o,
  output logic sck_o,
  output logic lrck_o,
  output logic boundary_o,
  output logic capture_o
);

  localparam int unsigned CNT_W   = LRCK_BIT + 1;
  localparam int unsigned SCK_BIT = LRCK_BIT - 5;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: plain increment, wraps to zero at the end of the frame.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Divider counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mclk_o = cnt_q[MCLK_BIT];
  assign sck_o  = cnt_q[SCK_BIT];
  assign lrck_o = cnt_q[LRCK_BIT];

  // Last clk of a slot: SCK falls on the following edge.
  assign boundary_o = &cnt_q[SCK_BIT:0];
  // Last clk of slot 0 only (cnt == 31 at default sizing).
  assign capture_o  = boundary_o & ~(|cnt_q[LRCK_BIT:SCK_BIT+1]);

endmodule

// File: rtl/speaker_control.sv
// I2S serialiser for the on-board DAC: captures {left,right} once per frame
// and shifts it out MSB first with the I2S one-bit delay after LRCK.
// Optional feature macro: SPEAKER_MUTE_EN adds a `mute` input that zeroes
// the word loaded on the capture cycle (frame-granular mute).
module speaker_control
  import speaker_control_pkg::*;
#(
  parameter int unsigned LRCK_BIT = LRCK_BIT_DEF,
  parameter int unsigned MCLK_BIT = MCLK_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] audio_left,
  input  logic [DATA_W-1:0] audio_right,
`ifdef SPEAKER_MUTE_EN
  input  logic              mute,
`endif
  output logic              audio_mclk,
  output logic              audio_lrck,
  output logic              audio_sck,
  output logic              audio_sdin,
  output logic              sample_tick
);

  localparam int unsigned SR_W = 2 * DATA_W;

  logic            boundary;
  logic            capture;
  logic [SR_W-1:0] load_word;
  logic [SR_W-1:0] sr_q;
  logic [SR_W-1:0] sr_d;

  i2s_clk_gen #(
    .LRCK_BIT (LRCK_BIT),
    .MCLK_BIT (MCLK_BIT)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .mclk_o     (audio_mclk),
    .sck_o      (audio_sck),
    .lrck_o     (audio_lrck),
    .boundary_o (boundary),
    .capture_o  (capture)
  );

  // Word presented to the shift register on the capture cycle.
  always_comb begin
`ifdef SPEAKER_MUTE_EN
    load_word = mute ? '0 : {audio_left, audio_right};
`else
    load_word = {audio_left, audio_right};
`endif
  end

  // Load at end of slot 0, shift one bit at every other slot boundary.
  always_comb begin
    sr_d = sr_q;
    if (capture) begin
      sr_d = load_word;
    end else if (boundary) begin
      sr_d = {sr_q[SR_W-2:0], 1'b0};
    end
  end

  // Shift register; its MSB drives SDIN directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign audio_sdin  = sr_q[SR_W-1];
  assign sample_tick = capture;

endmodule

// File: tb/tb_speaker_control.sv
// Self-checking bench for speaker_control: a frame-position reference model
// checks every output each cycle, and a serial decoder recovers L/R words.
module tb_speaker_control;

  localparam int unsigned FRAME = 1024;
  localparam int unsigned SLOT  = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] audio_left = '0;
  logic [15:0] audio_right = '0;
`ifdef SPEAKER_MUTE_EN
  logic        mute = 1'b0;
`endif
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        sample_tick;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  speaker_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .audio_left  (audio_left),
    .audio_right (audio_right),
`ifdef SPEAKER_MUTE_EN
    .mute        (mute),
`endif
    .audio_mclk  (audio_mclk),
    .audio_lrck  (audio_lrck),
    .audio_sck   (audio_sck),
    .audio_sdin  (audio_sdin),
    .sample_tick (sample_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: clk count since reset and the word captured in the
  // current frame. Outputs follow from frame position arithmetic.
  int unsigned mcnt = 0;
  logic [31:0] mword = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt  <= 0;
      mword <= '0;
    end else begin
      if (mcnt % FRAME == 31) begin
`ifdef SPEAKER_MUTE_EN
        mword <= mute ? 32'h0 : {audio_left, audio_right};
`else
        mword <= {audio_left, audio_right};
`endif
      end
      mcnt <= mcnt + 1;
    end
  end

  function automatic logic [4:0] model_out();
    int unsigned p;
    int unsigned slot;
    logic mc, sc, lr, tk, sd;
    p    = mcnt % FRAME;
    slot = p / SLOT;
    mc   = ((p / 2) % 2) == 1;
    sc   = ((p / 16) % 2) == 1;
    lr   = (p / 512) == 1;
    tk   = (p == 31);
    sd   = (slot == 0) ? mword[0] : mword[32 - slot];
    return {mc, sc, lr, tk, sd};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("stream{mclk,sck,lrck,tick,sdin}",
          32'({audio_mclk, audio_sck, audio_lrck, sample_tick, audio_sdin}),
          32'(model_out()));
    end
  end

  // Decode one frame starting at the next LRCK fall, sampling SDIN on SCK
  // rising edges. Optionally changes audio_left chg_at clks into the frame.
  task automatic decode_frame(input int unsigned chg_at, input logic [15:0] chg_l,
                              output logic [15:0] l, output logic [15:0] r,
                              output logic ok);
    logic sb [0:32];
    logic prev_lrck, prev_sck, found;
    int unsigned rises, cyc;
    for (int i = 0; i < 33; i++) sb[i] = 1'b0;
    found = 1'b0;
    @(negedge clk);
    prev_lrck = audio_lrck;
    for (int i = 0; i < 2100 && !found; i++) begin
      @(negedge clk);
      if (prev_lrck && !audio_lrck) found = 1'b1;
      prev_lrck = audio_lrck;
    end
    rises = 0;
    cyc = 0;
    prev_sck = audio_sck;
    for (int i = 0; i < 1100 && found && rises < 33; i++) begin
      @(negedge clk);
      cyc++;
      if (chg_at != 0 && cyc == chg_at) audio_left = chg_l;
      if (!prev_sck && audio_sck) begin
        sb[rises] = audio_sdin;
        rises++;
      end
      prev_sck = audio_sck;
    end
    for (int j = 0; j < 16; j++) l[15-j] = sb[1+j];
    for (int j = 0; j < 15; j++) r[15-j] = sb[17+j];
    r[0] = sb[32];
    ok = found && (rises == 33);
  endtask

  task automatic wait_phase(input int unsigned ph);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 2100 && !hit; i++) begin
      @(negedge clk);
      if (mcnt % FRAME == ph) hit = 1'b1;
    end
    chk("wait_phase_reached", 32'(hit), 32'd1);
  endtask

  task automatic count_to_tick(input string name);
    int unsigned edges;
    logic found;
    edges = 0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      edges++;
      if (sample_tick) found = 1'b1;
    end
    chk(name, edges, 32'd31);
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [15:0] dl, dr;
    logic ok;
    logic pm, ps, pl;
    int unsigned nm, ns, nl, nt, lhigh;
    vec_t v;

    tbl.push_back('{16'hA5C3, 16'h3C5A, 16'hA5C3, 16'h3C5A});
    tbl.push_back('{16'h0000, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000});
    tbl.push_back('{16'h8000, 16'h0001, 16'h8000, 16'h0001});
    tbl.push_back('{16'h7FFF, 16'h8001, 16'h7FFF, 16'h8001});
    for (int i = 0; i < 3; i++) begin
      v.l = 16'($urandom);
      v.r = 16'($urandom);
      v.exp_l = v.l;
      v.exp_r = v.r;
      tbl.push_back(v);
    end

    // Reset held 5 clk, outputs all zero throughout.
    mon_en = 1'b1;
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs_zero",
          32'({audio_mclk, audio_sck, audio_lrck, sample_tick, audio_sdin}), 32'd0);
    end
    rst_n = 1'b1;
    count_to_tick("first_tick_edges_after_release");

    // Three frames of free run: divider periods and tick rate.
    nm = 0; ns = 0; nl = 0; nt = 0; lhigh = 0;
    @(negedge clk);
    pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (!pm && audio_mclk) nm++;
      if (!ps && audio_sck) ns++;
      if (!pl && audio_lrck) nl++;
      if (audio_lrck) lhigh++;
      if (sample_tick) nt++;
      pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
    end
    chk("mclk_rises_3_frames", nm, 32'd768);
    chk("sck_rises_3_frames", ns, 32'd96);
    chk("lrck_rises_3_frames", nl, 32'd3);
    chk("lrck_high_clks", lhigh, 32'd1536);
    chk("ticks_3_frames", nt, 32'd3);

    // Table-driven serial decode.
    foreach (tbl[i]) begin
      audio_left  = tbl[i].l;
      audio_right = tbl[i].r;
      decode_frame(0, 16'h0, dl, dr, ok);
      chk("decode_done", 32'(ok), 32'd1);
      chk("decode_left", 32'(dl), 32'(tbl[i].exp_l));
      chk("decode_right", 32'(dr), 32'(tbl[i].exp_r));
    end

    // Mid-frame change of the left sample only lands in the next frame.
    audio_left  = 16'h0001;
    audio_right = 16'h1234;
    decode_frame(600, 16'h8000, dl, dr, ok);
    chk("midchange_done", 32'(ok), 32'd1);
    chk("midchange_cur_left", 32'(dl), 32'h0001);
    chk("midchange_cur_right", 32'(dr), 32'h1234);
    decode_frame(0, 16'h0, dl, dr, ok);
    chk("midchange_next_done", 32'(ok), 32'd1);
    chk("midchange_next_left", 32'(dl), 32'h8000);

    // Random input churn at arbitrary times; the model checks every cycle.
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 63) == 0) begin
        audio_left  = 16'($urandom);
        audio_right = 16'($urandom);
      end
    end

`ifdef SPEAKER_MUTE_EN
    // Mute across capture gives a zero frame; unmute mid-frame waits a frame.
    audio_left  = 16'h7FFF;
    audio_right = 16'h7FFF;
    mute = 1'b1;
    decode_frame(0, 16'h7FFF, dl, dr, ok);
    chk("mute_done", 32'(ok), 32'd1);
    chk("mute_left", 32'(dl), 32'h0);
    chk("mute_right", 32'(dr), 32'h0);
    wait_phase(600);
    mute = 1'b0;
    repeat (100) @(negedge clk);
    chk("mute_still_zero_sdin", 32'(audio_sdin), 32'd0);
    decode_frame(0, 16'h7FFF, dl, dr, ok);
    chk("unmute_done", 32'(ok), 32'd1);
    chk("unmute_left", 32'(dl), 32'h7FFF);
    chk("unmute_right", 32'(dr), 32'h7FFF);
`endif

    // Asynchronous reset mid-frame with a non-zero shift register.
    audio_left  = 16'hFFFF;
    audio_right = 16'hFFFF;
    wait_phase(0);
    wait_phase(300);
    chk("pre_reset_sdin", 32'(audio_sdin), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs_zero",
        32'({audio_mclk, audio_sck, audio_lrck, sample_tick, audio_sdin}), 32'd0);
    repeat (3) @(negedge clk);
    chk("held_reset_outputs_zero",
        32'({audio_mclk, audio_sck, audio_lrck, sample_tick, audio_sdin}), 32'd0);
    rst_n = 1'b1;
    count_to_tick("restart_tick_edges");
    audio_left  = 16'hA5C3;
    audio_right = 16'h3C5A;
    decode_frame(0, 16'h0, dl, dr, ok);
    chk("post_reset_done", 32'(ok), 32'd1);
    chk("post_reset_left", 32'(dl), 32'hA5C3);
    chk("post_reset_right", 32'(dr), 32'h3C5A);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
